// File: rtl/collector_rr_arbiter.sv
// collector_rr_arbiter
// Shares one downstream collector between NUM_PORTS router local output ports.
// Upstream ports are served round-robin (one acceptance per two cycles) into a
// small circular FIFO; the FIFO head is offered to the collector with the same
// Req/Gnt handshake. Packet contents pass through untouched.
module collector_rr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int dataWidth  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS*dataWidth-1:0] PacketIn,
    input  logic [NUM_PORTS-1:0]           ReqUpStr,
    output logic [NUM_PORTS-1:0]           GntUpStr,
    output logic [NUM_PORTS-1:0]           UpStrFull,
    output logic [dataWidth-1:0]           PacketOut,
    output logic                           ReqDnStr,
    input  logic                           GntDnStr,
    input  logic                           DnStrFull,
    output logic [CNT_W-1:0]               FifoCount
);

    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam int AW    = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W:0]   NP_W     = (PTR_W+1)'(NUM_PORTS);
    localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(NUM_PORTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        U_IDLE,
        U_GRANT
    } u_state_t;

    typedef enum logic {
        D_IDLE,
        D_WAIT
    } d_state_t;

    // Upstream control state
    u_state_t               u_state_q, u_state_d;
    logic [PTR_W-1:0]       last_q, last_d;
    logic [NUM_PORTS-1:0]   gnt_q, gnt_d;

    // Downstream control state
    d_state_t               d_state_q, d_state_d;
    logic                   req_dn_q, req_dn_d;
    logic [dataWidth-1:0]   pkt_out_q, pkt_out_d;

    // FIFO bookkeeping
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   full_q, full_d;
    logic [dataWidth-1:0]   mem_q [FIFO_DEPTH];

    // Arbitration and handshake decode
    logic [dataWidth-1:0]   pkt_in [NUM_PORTS];
    logic [PTR_W:0]         scan_idx;
    logic [PTR_W-1:0]       winner;
    logic                   found;
    logic                   push;
    logic                   pop;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign pkt_in[gi] = PacketIn[gi*dataWidth +: dataWidth];
    end

    // Find the first requester after the last winner, wrapping modulo NUM_PORTS.
    always_comb begin
        found    = 1'b0;
        winner   = last_q;
        scan_idx = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            scan_idx = {1'b0, last_q} + (PTR_W+1)'(k);
            if (scan_idx >= NP_W) begin
                scan_idx = scan_idx - NP_W;
            end
            if (!found && ReqUpStr[scan_idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[PTR_W-1:0];
            end
        end
    end

    // A push only happens from U_IDLE with room in the FIFO, so it never overflows.
    assign push = (u_state_q == U_IDLE) && found && (count_q != FULL_CNT);

    // Upstream FSM: grant for exactly one cycle, then ignore requests for one cycle.
    always_comb begin
        u_state_d = u_state_q;
        last_d    = last_q;
        gnt_d     = '0;
        case (u_state_q)
            U_IDLE: begin
                if (push) begin
                    u_state_d     = U_GRANT;
                    last_d        = winner;
                    gnt_d[winner] = 1'b1;
                end
            end
            U_GRANT: begin
                u_state_d = U_IDLE;
            end
            default: begin
                u_state_d = U_IDLE;
            end
        endcase
    end

    // Downstream FSM: present the FIFO head and hold it until the collector grants.
    always_comb begin
        d_state_d = d_state_q;
        req_dn_d  = req_dn_q;
        pkt_out_d = pkt_out_q;
        pop       = 1'b0;
        case (d_state_q)
            D_IDLE: begin
                if ((count_q != '0) && !DnStrFull) begin
                    d_state_d = D_WAIT;
                    req_dn_d  = 1'b1;
                    pkt_out_d = mem_q[rd_ptr_q];
                end
            end
            D_WAIT: begin
                if (GntDnStr) begin
                    d_state_d = D_IDLE;
                    req_dn_d  = 1'b0;
                    pop       = 1'b1;
                end
            end
            default: begin
                d_state_d = D_IDLE;
                req_dn_d  = 1'b0;
            end
        endcase
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == FULL_CNT);
    end

    // Control and output registers; reset discards buffered packets by clearing pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_state_q <= U_IDLE;
            last_q    <= LAST_RST;
            gnt_q     <= '0;
            d_state_q <= D_IDLE;
            req_dn_q  <= 1'b0;
            pkt_out_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
        end else begin
            u_state_q <= u_state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            d_state_q <= d_state_d;
            req_dn_q  <= req_dn_d;
            pkt_out_q <= pkt_out_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
        end
    end

    // Packet storage carries data only, so it is written without reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pkt_in[winner];
        end
    end

    assign GntUpStr  = gnt_q;
    assign UpStrFull = {NUM_PORTS{full_q}};
    assign PacketOut = pkt_out_q;
    assign ReqDnStr  = req_dn_q;
    assign FifoCount = count_q;

endmodule

// File: tb/tb_collector_rr_arbiter.sv
// Bench for collector_rr_arbiter: randomized requesters and collector checked
// against a queue-based behavioural model of the arbiter, plus directed scenarios.
`timescale 1ns/1ps
module tb_collector_rr_arbiter;

    localparam int NP    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*DW-1:0]  PacketIn;
    logic [NP-1:0]     ReqUpStr;
    logic [NP-1:0]     GntUpStr;
    logic [NP-1:0]     UpStrFull;
    logic [DW-1:0]     PacketOut;
    logic              ReqDnStr;
    logic              GntDnStr;
    logic              DnStrFull;
    logic [CW-1:0]     FifoCount;

    always #5 clk = ~clk;

    collector_rr_arbiter #(
        .NUM_PORTS (NP),
        .dataWidth (DW),
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .PacketIn (PacketIn),
        .ReqUpStr (ReqUpStr),
        .GntUpStr (GntUpStr),
        .UpStrFull(UpStrFull),
        .PacketOut(PacketOut),
        .ReqDnStr (ReqDnStr),
        .GntDnStr (GntDnStr),
        .DnStrFull(DnStrFull),
        .FifoCount(FifoCount)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: queue of buffered packets plus handshake flags
    logic [DW-1:0] m_q[$];
    int            m_last;
    bit            m_ugrant;
    bit            m_dwait;
    logic [NP-1:0] m_gnt;
    logic          m_req;
    logic [DW-1:0] m_pkt;
    logic [CW-1:0] m_cnt;
    logic          m_full;

    // Stimulus knobs
    logic [NP-1:0] en_mask;
    int            req_prob, gap, gmode, fmode, pkt_mode, raise_left;
    logic [DW-1:0] fixed_pkt;
    logic [DW-1:0] seq_ctr;
    int            hold [NP];
    logic [DW-1:0] cur_pkt [NP];

    function automatic void model_reset();
        m_q.delete();
        m_last   = NP - 1;
        m_ugrant = 1'b0;
        m_dwait  = 1'b0;
        m_gnt    = '0;
        m_req    = 1'b0;
        m_pkt    = '0;
        m_cnt    = '0;
        m_full   = 1'b0;
    endfunction

    // Advance one clock: apply the arbiter rules to the inputs sampled at the edge.
    task automatic tick();
        logic [NP-1:0] r;
        logic          g, f;
        int            win;
        bit            do_push, do_pop;
        logic [DW-1:0] pk;
        @(posedge clk);
        r = ReqUpStr; g = GntDnStr; f = DnStrFull;
        do_push = 1'b0; do_pop = 1'b0; win = 0; pk = '0;
        if (!m_ugrant && (r != '0) && (m_q.size() < DEPTH)) begin
            for (int k = 1; k <= NP; k++) begin
                if (!do_push && r[(m_last + k) % NP]) begin
                    win = (m_last + k) % NP;
                    do_push = 1'b1;
                end
            end
            pk = PacketIn[win*DW +: DW];
        end
        m_gnt = '0;
        if (do_push) begin
            m_gnt[win] = 1'b1;
            m_last = win;
        end
        m_ugrant = do_push;
        if (!m_dwait) begin
            if ((m_q.size() > 0) && !f) begin
                m_pkt = m_q[0]; m_req = 1'b1; m_dwait = 1'b1;
            end
        end else if (g) begin
            m_req = 1'b0; m_dwait = 1'b0; do_pop = 1'b1;
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(pk);
        m_cnt  = CW'(m_q.size());
        m_full = (m_q.size() == DEPTH);
        #1;
    endtask

    // Drive requesters and collector at the falling edge.
    task automatic drive_cycle();
        @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            if (ReqUpStr[i] && m_gnt[i]) begin
                ReqUpStr[i] = 1'b0;
                hold[i] = gap;
            end else if (!ReqUpStr[i]) begin
                if (hold[i] > 0) begin
                    hold[i]--;
                end else if (en_mask[i] && (raise_left > 0) && (int'($urandom_range(99)) < req_prob)) begin
                    raise_left--;
                    case (pkt_mode)
                        0:       cur_pkt[i] = $urandom();
                        1:       begin seq_ctr = seq_ctr + 1; cur_pkt[i] = seq_ctr; end
                        default: cur_pkt[i] = fixed_pkt;
                    endcase
                    PacketIn[i*DW +: DW] = cur_pkt[i];
                    ReqUpStr[i] = 1'b1;
                end
            end
        end
        case (gmode)
            0:       GntDnStr = 1'b0;
            1:       GntDnStr = m_req;
            2:       GntDnStr = m_req & ($urandom_range(1) == 1);
            default: begin GntDnStr = 1'b1; gmode = 0; end
        endcase
        case (fmode)
            0:       DnStrFull = 1'b0;
            1:       DnStrFull = 1'b1;
            default: DnStrFull = ($urandom_range(4) == 0);
        endcase
    endtask

    task automatic set_knobs(input logic [NP-1:0] en, input int prob, input int g,
                             input int gm, input int fm, input int pm, input int nraise);
        en_mask = en; req_prob = prob; gap = g; gmode = gm; fmode = fm;
        pkt_mode = pm; raise_left = nraise;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        ReqUpStr = '0; GntDnStr = 1'b0; DnStrFull = 1'b0; PacketIn = '0;
        for (int i = 0; i < NP; i++) hold[i] = 0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        if (GntUpStr !== '0)  begin n_err++; $display("FAIL reset gnt got %b want 0", GntUpStr); end
        if (UpStrFull !== '0) begin n_err++; $display("FAIL reset full got %b want 0", UpStrFull); end
        if (ReqDnStr !== 1'b0) begin n_err++; $display("FAIL reset reqdn got %b want 0", ReqDnStr); end
        if (PacketOut !== '0) begin n_err++; $display("FAIL reset pktout got %h want 0", PacketOut); end
        if (FifoCount !== '0) begin n_err++; $display("FAIL reset count got %0d want 0", FifoCount); end
        n_vec += 5;
    endtask

    task automatic test_single_port();
        string tag = "single";
        int gc = -1, rc = -1, ngnt = 0, cnt_at_g = -1;
        logic [DW-1:0] pk_seen = '0;
        apply_reset();
        set_knobs(4'b0100, 100, 0, 1, 0, 2, 1);
        fixed_pkt = 32'h0000_ABCD;
        for (int c = 0; c < 8; c++) begin
            drive_cycle(); tick();
            if (GntUpStr !== m_gnt) begin n_err++; $display("FAIL %s gnt got %b want %b", tag, GntUpStr, m_gnt); end
            if (UpStrFull !== {NP{m_full}}) begin n_err++; $display("FAIL %s full got %b want %b", tag, UpStrFull, {NP{m_full}}); end
            if (ReqDnStr !== m_req) begin n_err++; $display("FAIL %s reqdn got %b want %b", tag, ReqDnStr, m_req); end
            if (PacketOut !== m_pkt) begin n_err++; $display("FAIL %s pktout got %h want %h", tag, PacketOut, m_pkt); end
            if (FifoCount !== m_cnt) begin n_err++; $display("FAIL %s count got %0d want %0d", tag, FifoCount, m_cnt); end
            n_vec += 5;
            if (GntUpStr === 4'b0100) begin
                ngnt++;
                if (gc < 0) begin gc = c; cnt_at_g = int'(FifoCount); end
            end
            if ((ReqDnStr === 1'b1) && (rc < 0)) begin rc = c; pk_seen = PacketOut; end
        end
        if (ngnt !== 1) begin n_err++; $display("FAIL single_gnt_pulses got %0d want 1", ngnt); end
        if (rc !== gc + 1) begin n_err++; $display("FAIL single_reqdn_latency got cycle %0d want %0d", rc, gc + 1); end
        if (pk_seen !== 32'h0000_ABCD) begin n_err++; $display("FAIL single_pktout got %h want 0000abcd", pk_seen); end
        if (cnt_at_g !== 1) begin n_err++; $display("FAIL single_count_after_push got %0d want 1", cnt_at_g); end
        if (FifoCount !== '0) begin n_err++; $display("FAIL single_count_final got %0d want 0", FifoCount); end
        n_vec += 5;
    endtask

    task automatic test_round_robin();
        string tag = "rr";
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        int order[$];
        int gcyc[$];
        logic [DW-1:0] gp[$];
        logic [DW-1:0] op[$];
        logic prev_req = 1'b0;
        apply_reset();
        set_knobs(4'b1111, 100, 1, 1, 0, 0, 1000000);
        for (int c = 0; c < 20; c++) begin
            drive_cycle(); tick();
            if (GntUpStr !== m_gnt) begin n_err++; $display("FAIL %s gnt got %b want %b", tag, GntUpStr, m_gnt); end
            if (UpStrFull !== {NP{m_full}}) begin n_err++; $display("FAIL %s full got %b want %b", tag, UpStrFull, {NP{m_full}}); end
            if (ReqDnStr !== m_req) begin n_err++; $display("FAIL %s reqdn got %b want %b", tag, ReqDnStr, m_req); end
            if (PacketOut !== m_pkt) begin n_err++; $display("FAIL %s pktout got %h want %h", tag, PacketOut, m_pkt); end
            if (FifoCount !== m_cnt) begin n_err++; $display("FAIL %s count got %0d want %0d", tag, FifoCount, m_cnt); end
            n_vec += 5;
            for (int i = 0; i < NP; i++) begin
                if (GntUpStr[i] === 1'b1) begin
                    order.push_back(i); gcyc.push_back(c); gp.push_back(cur_pkt[i]);
                end
            end
            if ((ReqDnStr === 1'b1) && !prev_req) op.push_back(PacketOut);
            prev_req = ReqDnStr;
        end
        for (int k = 0; k < 6; k++) begin
            int got;
            got = (k < order.size()) ? order[k] : -1;
            if (got !== exp_order[k]) begin n_err++; $display("FAIL rr_order[%0d] got %0d want %0d", k, got, exp_order[k]); end
            n_vec++;
        end
        for (int k = 1; k < 6; k++) begin
            int d;
            d = (k < gcyc.size()) ? gcyc[k] - gcyc[k-1] : -1;
            if (d !== 2) begin n_err++; $display("FAIL rr_spacing[%0d] got %0d want 2", k, d); end
            n_vec++;
        end
        if (op.size() < 6) begin n_err++; $display("FAIL rr_drained got %0d want >=6", op.size()); end
        n_vec++;
        for (int k = 0; k < op.size() && k < gp.size(); k++) begin
            if (op[k] !== gp[k]) begin n_err++; $display("FAIL rr_pkt_order[%0d] got %h want %h", k, op[k], gp[k]); end
            n_vec++;
        end
    endtask

    task automatic test_back_pressure();
        string tag = "bp";
        int ngnt = 0;
        apply_reset();
        set_knobs(4'b0011, 100, 0, 0, 0, 0, 1000000);
        for (int c = 0; c < 14; c++) begin
            drive_cycle(); tick();
            if (GntUpStr !== m_gnt) begin n_err++; $display("FAIL %s gnt got %b want %b", tag, GntUpStr, m_gnt); end
            if (UpStrFull !== {NP{m_full}}) begin n_err++; $display("FAIL %s full got %b want %b", tag, UpStrFull, {NP{m_full}}); end
            if (ReqDnStr !== m_req) begin n_err++; $display("FAIL %s reqdn got %b want %b", tag, ReqDnStr, m_req); end
            if (PacketOut !== m_pkt) begin n_err++; $display("FAIL %s pktout got %h want %h", tag, PacketOut, m_pkt); end
            if (FifoCount !== m_cnt) begin n_err++; $display("FAIL %s count got %0d want %0d", tag, FifoCount, m_cnt); end
            n_vec += 5;
            if (GntUpStr !== '0) ngnt++;
        end
        if (ngnt !== 4) begin n_err++; $display("FAIL bp_grants got %0d want 4", ngnt); end
        if (FifoCount !== 3'd4) begin n_err++; $display("FAIL bp_count_full got %0d want 4", FifoCount); end
        if (UpStrFull !== 4'b1111) begin n_err++; $display("FAIL bp_full got %b want 1111", UpStrFull); end
        n_vec += 3;
        gmode = 3;
        drive_cycle(); tick();
        if (FifoCount !== 3'd3) begin n_err++; $display("FAIL bp_count_after_pop got %0d want 3", FifoCount); end
        if (UpStrFull !== 4'b0000) begin n_err++; $display("FAIL bp_full_after_pop got %b want 0000", UpStrFull); end
        n_vec += 2;
        drive_cycle(); tick();
        if (GntUpStr !== 4'b0001) begin n_err++; $display("FAIL bp_next_grant got %b want 0001", GntUpStr); end
        if (FifoCount !== m_cnt) begin n_err++; $display("FAIL %s count got %0d want %0d", tag, FifoCount, m_cnt); end
        n_vec += 2;
    endtask

    task automatic test_dnstr_full();
        string tag = "dnfull";
        logic [DW-1:0] op[$];
        logic prev_req = 1'b0;
        apply_reset();
        seq_ctr = '0;
        set_knobs(4'b0001, 100, 0, 1, 1, 1, 2);
        for (int c = 0; c < 10; c++) begin
            drive_cycle(); tick();
            if (GntUpStr !== m_gnt) begin n_err++; $display("FAIL %s gnt got %b want %b", tag, GntUpStr, m_gnt); end
            if (ReqDnStr !== 1'b0) begin n_err++; $display("FAIL %s reqdn_blocked got %b want 0", tag, ReqDnStr); end
            if (FifoCount !== m_cnt) begin n_err++; $display("FAIL %s count got %0d want %0d", tag, FifoCount, m_cnt); end
            n_vec += 3;
        end
        if (FifoCount !== 3'd2) begin n_err++; $display("FAIL dnfull_buffered got %0d want 2", FifoCount); end
        n_vec++;
        fmode = 0;
        drive_cycle(); tick();
        if (ReqDnStr !== 1'b1) begin n_err++; $display("FAIL dnfull_release_req got %b want 1", ReqDnStr); end
        if (PacketOut !== 32'd1) begin n_err++; $display("FAIL dnfull_first_pkt got %h want 1", PacketOut); end
        n_vec += 2;
        prev_req = ReqDnStr;
        op.push_back(PacketOut);
        for (int c = 0; c < 8; c++) begin
            drive_cycle(); tick();
            if (ReqDnStr !== m_req) begin n_err++; $display("FAIL %s reqdn got %b want %b", tag, ReqDnStr, m_req); end
            if (PacketOut !== m_pkt) begin n_err++; $display("FAIL %s pktout got %h want %h", tag, PacketOut, m_pkt); end
            if (FifoCount !== m_cnt) begin n_err++; $display("FAIL %s count got %0d want %0d", tag, FifoCount, m_cnt); end
            n_vec += 3;
            if ((ReqDnStr === 1'b1) && !prev_req) op.push_back(PacketOut);
            prev_req = ReqDnStr;
        end
        if ((op.size() !== 2) || (op[op.size()-1] !== 32'd2)) begin
            n_err++; $display("FAIL dnfull_drain_order got %0d pkts last %h want 2 pkts last 2", op.size(), op[op.size()-1]);
        end
        n_vec++;
    endtask

    task automatic test_wrap_stream();
        string tag = "wrap";
        logic [DW-1:0] op[$];
        logic prev_req = 1'b0;
        int maxc = 0;
        apply_reset();
        seq_ctr = '0;
        set_knobs(4'b0001, 100, 0, 1, 0, 1, 10);
        for (int c = 0; c < 40; c++) begin
            drive_cycle(); tick();
            if (GntUpStr !== m_gnt) begin n_err++; $display("FAIL %s gnt got %b want %b", tag, GntUpStr, m_gnt); end
            if (UpStrFull !== {NP{m_full}}) begin n_err++; $display("FAIL %s full got %b want %b", tag, UpStrFull, {NP{m_full}}); end
            if (ReqDnStr !== m_req) begin n_err++; $display("FAIL %s reqdn got %b want %b", tag, ReqDnStr, m_req); end
            if (PacketOut !== m_pkt) begin n_err++; $display("FAIL %s pktout got %h want %h", tag, PacketOut, m_pkt); end
            if (FifoCount !== m_cnt) begin n_err++; $display("FAIL %s count got %0d want %0d", tag, FifoCount, m_cnt); end
            n_vec += 5;
            if ((ReqDnStr === 1'b1) && !prev_req) op.push_back(PacketOut);
            prev_req = ReqDnStr;
            if (int'(FifoCount) > maxc) maxc = int'(FifoCount);
        end
        if (op.size() !== 10) begin n_err++; $display("FAIL wrap_pkt_count got %0d want 10", op.size()); end
        n_vec++;
        for (int k = 0; k < op.size() && k < 10; k++) begin
            if (op[k] !== DW'(k + 1)) begin n_err++; $display("FAIL wrap_order[%0d] got %h want %h", k, op[k], k + 1); end
            n_vec++;
        end
        if (maxc > DEPTH) begin n_err++; $display("FAIL wrap_max_count got %0d want <=4", maxc); end
        n_vec++;
    endtask

    task automatic test_random();
        string tag = "rand";
        apply_reset();
        set_knobs(4'b1111, 40, 0, 2, 2, 0, 1000000);
        for (int c = 0; c < 400; c++) begin
            drive_cycle(); tick();
            if (GntUpStr !== m_gnt) begin n_err++; $display("FAIL %s gnt got %b want %b", tag, GntUpStr, m_gnt); end
            if (UpStrFull !== {NP{m_full}}) begin n_err++; $display("FAIL %s full got %b want %b", tag, UpStrFull, {NP{m_full}}); end
            if (ReqDnStr !== m_req) begin n_err++; $display("FAIL %s reqdn got %b want %b", tag, ReqDnStr, m_req); end
            if (PacketOut !== m_pkt) begin n_err++; $display("FAIL %s pktout got %h want %h", tag, PacketOut, m_pkt); end
            if (FifoCount !== m_cnt) begin n_err++; $display("FAIL %s count got %0d want %0d", tag, FifoCount, m_cnt); end
            n_vec += 5;
        end
    endtask

    task automatic test_reset_midop();
        string tag = "midrst";
        bit reached = 1'b0;
        apply_reset();
        set_knobs(4'b1111, 100, 0, 0, 0, 0, 1000000);
        for (int c = 0; c < 20 && !reached; c++) begin
            drive_cycle(); tick();
            if (GntUpStr !== m_gnt) begin n_err++; $display("FAIL %s gnt got %b want %b", tag, GntUpStr, m_gnt); end
            if (ReqDnStr !== m_req) begin n_err++; $display("FAIL %s reqdn got %b want %b", tag, ReqDnStr, m_req); end
            if (FifoCount !== m_cnt) begin n_err++; $display("FAIL %s count got %0d want %0d", tag, FifoCount, m_cnt); end
            n_vec += 3;
            if (m_ugrant && m_dwait) reached = 1'b1;
        end
        if (!reached) begin n_err++; $display("FAIL midrst_setup got no grant+wait state want both"); end
        n_vec++;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        if (GntUpStr !== '0)  begin n_err++; $display("FAIL midrst_gnt got %b want 0", GntUpStr); end
        if (UpStrFull !== '0) begin n_err++; $display("FAIL midrst_full got %b want 0", UpStrFull); end
        if (ReqDnStr !== 1'b0) begin n_err++; $display("FAIL midrst_reqdn got %b want 0", ReqDnStr); end
        if (PacketOut !== '0) begin n_err++; $display("FAIL midrst_pktout got %h want 0", PacketOut); end
        if (FifoCount !== '0) begin n_err++; $display("FAIL midrst_count got %0d want 0", FifoCount); end
        n_vec += 5;
        for (int i = 0; i < NP; i++) hold[i] = 0;
        ReqUpStr = '1;
        GntDnStr = 1'b0;
        reset = 1'b1;
        gmode = 1;
        drive_cycle(); tick();
        if (GntUpStr !== 4'b0001) begin n_err++; $display("FAIL midrst_first_winner got %b want 0001", GntUpStr); end
        if (GntUpStr !== m_gnt) begin n_err++; $display("FAIL %s gnt got %b want %b", tag, GntUpStr, m_gnt); end
        if (FifoCount !== m_cnt) begin n_err++; $display("FAIL %s count got %0d want %0d", tag, FifoCount, m_cnt); end
        n_vec += 3;
    endtask

    initial begin
        reset     = 1'b0;
        ReqUpStr  = '0;
        PacketIn  = '0;
        GntDnStr  = 1'b0;
        DnStrFull = 1'b0;
        seq_ctr   = '0;
        fixed_pkt = '0;
        for (int i = 0; i < NP; i++) begin hold[i] = 0; cur_pkt[i] = '0; end
        set_knobs('0, 0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_single_port();
        test_round_robin();
        test_back_pressure();
        test_dnstr_full();
        test_wrap_stream();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
